// File: rtl/sixteen_bit_1x16_demux_reg.sv
// Registered 1-to-16 demultiplexer with burst auto-increment and per-channel update strobes.
// Optional shadow/commit double buffering is built when DEMUX_DOUBLE_BUFFER_EN is defined.
module sixteen_bit_1x16_demux_reg #(
  parameter int                 DATA_W    = 16,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_select,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_burst,
  input  logic [3:0]        i_burst_len,
  input  logic              i_commit,
  output logic [DATA_W-1:0] o_0,
  output logic [DATA_W-1:0] o_1,
  output logic [DATA_W-1:0] o_2,
  output logic [DATA_W-1:0] o_3,
  output logic [DATA_W-1:0] o_4,
  output logic [DATA_W-1:0] o_5,
  output logic [DATA_W-1:0] o_6,
  output logic [DATA_W-1:0] o_7,
  output logic [DATA_W-1:0] o_8,
  output logic [DATA_W-1:0] o_9,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [DATA_W-1:0] o_c,
  output logic [DATA_W-1:0] o_d,
  output logic [DATA_W-1:0] o_e,
  output logic [DATA_W-1:0] o_f,
  output logic [15:0]       o_update,
  output logic              o_burst_done
);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        ptr, ptr_nxt;
  logic [4:0]        cnt, cnt_nxt;
  logic              xfer;
  logic              wr_en;
  logic [3:0]        wr_sel;
  logic [15:0]       wr_mask;
  logic              done_nxt;
  logic [DATA_W-1:0] slot_q [16];

  assign xfer    = i_valid & o_ready;
  assign wr_mask = wr_en ? (16'(1) << wr_sel) : 16'h0000;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    wr_en     = xfer;
    wr_sel    = i_select;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (o_ready && i_burst) begin
          if (i_valid) begin
            // The start word itself is the first burst word.
            ptr_nxt = i_select + 4'd1;
            cnt_nxt = {1'b0, i_burst_len};
            if (i_burst_len == 4'd0) done_nxt = 1'b1;
            else                     state_nxt = S_BURST;
          end else begin
            ptr_nxt   = i_select;
            cnt_nxt   = {1'b0, i_burst_len} + 5'd1;
            state_nxt = S_BURST;
          end
        end
      end
      S_BURST: begin
        wr_sel = ptr;
        if (xfer) begin
          ptr_nxt = ptr + 4'd1;
          cnt_nxt = cnt - 5'd1;
          if (cnt == 5'd1) begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_IDLE;
      ptr          <= 4'd0;
      cnt          <= 5'd0;
      o_ready      <= 1'b0;
      o_burst_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      cnt          <= cnt_nxt;
      o_ready      <= 1'b1;
      o_burst_done <= done_nxt;
    end
  end

`ifdef DEMUX_DOUBLE_BUFFER_EN
  logic [DATA_W-1:0] shadow_q [16];
  logic [15:0]       dirty_q;

  // NOTE: these arrays are held outputs with a defined reset value, so they are reset
  // in full rather than left as uninitialised RAM.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= RESET_VAL;
        slot_q[i]   <= RESET_VAL;
      end
      dirty_q  <= 16'h0000;
      o_update <= 16'h0000;
    end else begin
      if (wr_en) shadow_q[wr_sel] <= i_data;
      if (i_commit) begin
        // A write on the commit edge is passed straight through to its output.
        for (int i = 0; i < 16; i++)
          slot_q[i] <= wr_mask[i] ? i_data : shadow_q[i];
        o_update <= dirty_q | wr_mask;
        dirty_q  <= 16'h0000;
      end else begin
        o_update <= 16'h0000;
        dirty_q  <= dirty_q | wr_mask;
      end
    end
  end
`else
  logic commit_unused;
  assign commit_unused = i_commit;

  // NOTE: these arrays are held outputs with a defined reset value, so they are reset
  // in full rather than left as uninitialised RAM.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) slot_q[i] <= RESET_VAL;
      o_update <= 16'h0000;
    end else begin
      if (wr_en) slot_q[wr_sel] <= i_data;
      o_update <= wr_mask;
    end
  end
`endif

  assign o_0 = slot_q[0];
  assign o_1 = slot_q[1];
  assign o_2 = slot_q[2];
  assign o_3 = slot_q[3];
  assign o_4 = slot_q[4];
  assign o_5 = slot_q[5];
  assign o_6 = slot_q[6];
  assign o_7 = slot_q[7];
  assign o_8 = slot_q[8];
  assign o_9 = slot_q[9];
  assign o_a = slot_q[10];
  assign o_b = slot_q[11];
  assign o_c = slot_q[12];
  assign o_d = slot_q[13];
  assign o_e = slot_q[14];
  assign o_f = slot_q[15];

endmodule
